// File: rtl/vga_pkg.sv
// 640x480@60 raster timing defaults, shared position types and raster-region helpers.
// Pure declarations: no state, no latency, no flow control.
package vga_pkg;

    localparam int unsigned CNT_W = 10;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;

    localparam int unsigned H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int unsigned V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    typedef logic [CNT_W-1:0] cnt_t;
    // One bit wider than a counter so limits up to 1024 stay representable.
    typedef logic [CNT_W:0]   lim_t;

    typedef struct packed {
        cnt_t h;
        cnt_t v;
    } pos_t;

    function automatic logic visible(input cnt_t h, input cnt_t v,
                                     input lim_t h_act, input lim_t v_act);
        return ({1'b0, h} < h_act) && ({1'b0, v} < v_act);
    endfunction

    function automatic logic in_window(input cnt_t c, input lim_t lo, input lim_t hi);
        return ({1'b0, c} >= lo) && ({1'b0, c} <= hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_pix_clk_en.sv
// Divides clk by CLK_DIV into a one-clk pixel enable; combinational output, never stalls.
module pix_clk_en #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    output logic pix_tick_o
);

    localparam int unsigned     DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    // >= rather than == so an out-of-range count falls back to zero.
    always_comb begin
        div_d = (div_q >= DIV_LAST) ? '0 : div_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign pix_tick_o = (div_q == DIV_LAST) && rst_n_i;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster scan generator: pos/blank registered and aligned; h/vsync trail pos by SYNC_DELAY clk.
// Free-running, no backpressure; frame_start pulses for one clk on each wrap to (0,0).
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
    parameter int unsigned H_FP       = H_FP_DEF,
    parameter int unsigned H_SYNC     = H_SYNC_DEF,
    parameter int unsigned H_BP       = H_BP_DEF,
    parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
    parameter int unsigned V_FP       = V_FP_DEF,
    parameter int unsigned V_SYNC     = V_SYNC_DEF,
    parameter int unsigned V_BP       = V_BP_DEF,
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned SYNC_DELAY = 2,
    parameter logic        SYNC_POL   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] pos_h,
    output logic [CNT_W-1:0] pos_v,
    output logic             blank,
    output logic             hsync,
    output logic             vsync,
    output logic             pix_tick,
    output logic             frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);
    localparam lim_t H_ACT  = lim_t'(H_ACTIVE);
    localparam lim_t V_ACT  = lim_t'(V_ACTIVE);
    localparam lim_t HS_LO  = lim_t'(H_ACTIVE + H_FP);
    localparam lim_t HS_HI  = lim_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam lim_t VS_LO  = lim_t'(V_ACTIVE + V_FP);
    localparam lim_t VS_HI  = lim_t'(V_ACTIVE + V_FP + V_SYNC - 1);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 1024");
    end
    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be at least 1");
    end

    logic tick;

    pix_clk_en #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_clk_en (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .pix_tick_o (tick)
    );

    pos_t pos_q, pos_d;
    logic blank_q, blank_d;
    logic hraw_q, hraw_d;
    logic vraw_q, vraw_d;
    logic frame_q, frame_d;

    always_comb begin
        pos_d   = pos_q;
        frame_d = 1'b0;
        if (tick) begin
            if (pos_q.h >= H_LAST) begin
                // h and v wrap together on this edge; no (0, V_LAST) intermediate.
                pos_d.h = '0;
                pos_d.v = (pos_q.v >= V_LAST) ? '0 : pos_q.v + 1'b1;
                frame_d = (pos_q.h == H_LAST) && (pos_q.v == V_LAST);
            end else begin
                pos_d.h = pos_q.h + 1'b1;
                if (pos_q.v > V_LAST) begin
                    pos_d.v = '0;
                end
            end
        end
        blank_d = visible(pos_d.h, pos_d.v, H_ACT, V_ACT);
        hraw_d  = in_window(pos_d.h, HS_LO, HS_HI) ? SYNC_POL : ~SYNC_POL;
        vraw_d  = in_window(pos_d.v, VS_LO, VS_HI) ? SYNC_POL : ~SYNC_POL;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pos_q   <= '0;
            blank_q <= 1'b0;
            hraw_q  <= ~SYNC_POL;
            vraw_q  <= ~SYNC_POL;
            frame_q <= 1'b0;
        end else begin
            pos_q   <= pos_d;
            blank_q <= blank_d;
            hraw_q  <= hraw_d;
            vraw_q  <= vraw_d;
            frame_q <= frame_d;
        end
    end

    // Extra sync latency lets downstream colour pipelines stay aligned with the syncs.
    if (SYNC_DELAY == 0) begin : g_no_dly
        assign hsync = hraw_q;
        assign vsync = vraw_q;
    end else begin : g_dly
        logic [SYNC_DELAY-1:0] hs_q;
        logic [SYNC_DELAY-1:0] vs_q;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                hs_q <= {SYNC_DELAY{~SYNC_POL}};
                vs_q <= {SYNC_DELAY{~SYNC_POL}};
            end else begin
                hs_q <= SYNC_DELAY'({hs_q, hraw_q});
                vs_q <= SYNC_DELAY'({vs_q, vraw_q});
            end
        end

        assign hsync = hs_q[SYNC_DELAY-1];
        assign vsync = vs_q[SYNC_DELAY-1];
    end

    assign pos_h       = pos_q.h;
    assign pos_v       = pos_q.v;
    assign blank       = blank_q;
    assign pix_tick    = tick;
    assign frame_start = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Two small-raster instances (divided/delayed/active-low and undivided/undelayed/active-high) checked every clk.
module tb_vga_timing_gen;

    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    localparam int DIV_A = 4, DLY_A = 3;
    localparam bit POL_A = 1'b0;
    localparam int DIV_B = 1, DLY_B = 0;
    localparam bit POL_B = 1'b1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] pos_h_a, pos_v_a, pos_h_b, pos_v_b;
    logic       blank_a, hsync_a, vsync_a, tick_a, fs_a;
    logic       blank_b, hsync_b, vsync_b, tick_b, fs_b;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CLK_DIV(DIV_A), .SYNC_DELAY(DLY_A), .SYNC_POL(POL_A)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .pos_h(pos_h_a), .pos_v(pos_v_a), .blank(blank_a),
        .hsync(hsync_a), .vsync(vsync_a), .pix_tick(tick_a), .frame_start(fs_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CLK_DIV(DIV_B), .SYNC_DELAY(DLY_B), .SYNC_POL(POL_B)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .pos_h(pos_h_b), .pos_v(pos_v_b), .blank(blank_b),
        .hsync(hsync_b), .vsync(vsync_b), .pix_tick(tick_b), .frame_start(fs_b)
    );

    typedef struct packed {
        int ph;
        int pv;
        bit blank;
        bit hs;
        bit vs;
        bit tick;
        bit fs;
    } obs_t;

    typedef struct packed {
        obs_t a;
        obs_t b;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   k = 0;

    // k = clk edges with rst_n high since the last reset edge; pixel index is k / d.
    function automatic obs_t ref_model(input int k_i, input bit rn, input int d,
                                       input int sd, input bit pol);
        obs_t o;
        int   p, pr, hr, vr;
        o.tick = rn && ((k_i % d) == d - 1);
        if (k_i == 0) begin
            o.ph = 0; o.pv = 0; o.blank = 1'b0; o.fs = 1'b0;
        end else begin
            p       = k_i / d;
            o.ph    = p % HT;
            o.pv    = (p / HT) % VT;
            o.blank = (o.ph < HA) && (o.pv < VA);
            o.fs    = ((k_i % d) == 0) && ((p % (HT * VT)) == 0);
        end
        o.hs = ~pol;
        o.vs = ~pol;
        if (k_i - sd >= 1) begin
            pr = (k_i - sd) / d;
            hr = pr % HT;
            vr = (pr / HT) % VT;
            if (hr >= HA + HF && hr < HA + HF + HS) o.hs = pol;
            if (vr >= VA + VF && vr < VA + VF + VS) o.vs = pol;
        end
        return o;
    endfunction

    task automatic step(input bit rn);
        @(negedge clk);
        rst_n = rn;
        @(posedge clk);
        k = rn ? k + 1 : 0;
        exp_q.push_back('{a: ref_model(k, rn, DIV_A, DLY_A, POL_A),
                          b: ref_model(k, rn, DIV_B, DLY_B, POL_B)});
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at t=%0t: actual=%0d required=%0d", nm, $time, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("a_pos_h",       32'(pos_h_a), 32'(e.a.ph));
                check("a_pos_v",       32'(pos_v_a), 32'(e.a.pv));
                check("a_blank",       32'(blank_a), 32'(e.a.blank));
                check("a_hsync",       32'(hsync_a), 32'(e.a.hs));
                check("a_vsync",       32'(vsync_a), 32'(e.a.vs));
                check("a_pix_tick",    32'(tick_a),  32'(e.a.tick));
                check("a_frame_start", 32'(fs_a),    32'(e.a.fs));
                check("b_pos_h",       32'(pos_h_b), 32'(e.b.ph));
                check("b_pos_v",       32'(pos_v_b), 32'(e.b.pv));
                check("b_blank",       32'(blank_b), 32'(e.b.blank));
                check("b_hsync",       32'(hsync_b), 32'(e.b.hs));
                check("b_vsync",       32'(vsync_b), 32'(e.b.vs));
                check("b_pix_tick",    32'(tick_b),  32'(e.b.tick));
                check("b_frame_start", 32'(fs_b),    32'(e.b.fs));
            end
        end
    end

    initial begin : driver
        repeat (3) step(1'b0);
        repeat (1100) step(1'b1);
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(30, 600)) step(1'b1);
            repeat ($urandom_range(1, 2)) step(1'b0);
        end
        repeat (600) step(1'b1);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain: actual=%0d entries left, required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Upstream stage of the VGA pixel path; generates the raster scan that pixel generators (e.g. the circle renderer) consume.
- Divides the system clock down to a pixel-rate enable and runs the horizontal/vertical counters.
- Outputs current pixel position (pos_h, pos_v) and the visible-region flag (blank; 1 = visible, drive colour).
- Outputs hsync/vsync, delayable by SYNC_DELAY clk cycles to match downstream colour-pipeline latency.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 4, clk cycles per pixel (>=1)
- SYNC_DELAY, 2, clk cycles of extra delay on hsync/vsync (>=0)
- SYNC_POL, 0, active level of hsync/vsync

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- pos_h  out  10  current column, 0..H_TOTAL-1
- pos_v  out  10  current row, 0..V_TOTAL-1
- blank  out  1  1 when (pos_h,pos_v) is visible, else 0
- hsync  out  1  horizontal sync, delayed SYNC_DELAY clk
- vsync  out  1  vertical sync, delayed SYNC_DELAY clk
- pix_tick  out  1  one-clk pulse per pixel period
- frame_start  out  1  one-clk pulse when position wraps to (0,0)

Behaviour:
- Derived constants: H_TOTAL = sum of H_* (800); V_TOTAL = sum of V_* (525). Both must be <=1024; elaboration error otherwise.
- Divider div_cnt counts 0..CLK_DIV-1, then wraps. pix_tick = (div_cnt == CLK_DIV-1) and rst_n. With CLK_DIV=1, pix_tick is constant 1 out of reset.
- On a clk edge with pix_tick=1:
  - h_cnt increments.
  - At H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - At V_TOTAL-1 with h wrap, v_cnt wraps to 0.
- pos_h and pos_v are the h_cnt/v_cnt registers directly.
- blank is registered every edge from visible(next h, next v), where visible = h < H_ACTIVE and v < V_ACTIVE. blank is therefore aligned with pos_h/pos_v.
- Raw hsync is active for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751). Raw vsync is active for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491).
  - Raw sync is registered in the same way as blank, so it is aligned with pos.
  - Raw sync then passes through a SYNC_DELAY-stage shift register. SYNC_DELAY=0 means outputs are aligned with pos.
- frame_start is registered, high for exactly one clk, on the same cycle pos first shows (0,0) after a wrap from (H_TOTAL-1, V_TOTAL-1). It is not asserted on exit from reset.
- Reset values, on any edge with rst_n=0, including mid-frame:
  - div_cnt=0, pos_h=0, pos_v=0, blank=0.
  - hsync=vsync=~SYNC_POL, including every delay stage.
  - pix_tick=0, frame_start=0.
- First edge after rst_n rises: blank=1, since (0,0) is visible.
- Simultaneous h and v wrap: both take effect on the same edge, with no intermediate (0,V_TOTAL-1) state visible.
- Counters never exceed their totals. Any out-of-range state (unreachable) recovers to 0 on the next tick.

Decomposition:
- Package vga_pkg: 640x480@60 timing constants, derived H_TOTAL/V_TOTAL, and a function visible(h,v).
- One sub-module, pix_clk_en: a parameterised CLK_DIV divider producing pix_tick, with synchronous active-low reset.
- The sync delay line stays inline as a generate-based shift register.

Test Plan:
- Reset release, CLK_DIV=4 → pix_tick high on clk cycles 4, 8, 12… after release; pos_h=1 after cycle 4; blank=1 from cycle 1.
- Run one line → pos_h sequence 0..799 then 0, with pos_v incrementing at the wrap; blank falls at pos_h=640; raw hsync active for exactly 96 pixels (384 clk), starting SYNC_DELAY clk after pos_h=656.
- Run a full frame → frame_start pulses once per 800*525*4 = 1,680,000 clk; vsync active for 2 lines (6400 clk); blank=0 for all pos_v >= 480.
- SYNC_DELAY=0 vs 3 → hsync edge offset from the pos_h=656 transition by exactly 0 and 3 clk respectively.
- Assert rst_n=0 for 1 clk at pos (400,300) → next edge shows pos=(0,0), blank=0, syncs inactive, frame_start=0; normal count resumes.
- CLK_DIV=1 → pix_tick constant 1 out of reset; pos_h advances every clk; frame period is 420,000 clk.
